// File: rtl/chacha_core_iter.sv
// chacha_core_iter: iterative ChaCha block core with multi-block counter mode
module chacha_core_iter #(
    parameter int ROUNDS       = 20,
    parameter int DR_PER_CYCLE = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     state_in,
    input  logic [CNT_W-1:0] in_nblocks,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [511:0]     state_out,
    output logic             busy
);
    localparam int N  = ROUNDS / (2 * DR_PER_CYCLE);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    typedef logic [31:0] word_t;
    typedef logic [15:0][31:0] blk_t;
    typedef enum logic [1:0] {IDLE, ROUND, OUT} st_t;

    st_t              st_q, st_d;
    blk_t             work_q, work_d, orig_q, orig_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [CNT_W-1:0] blk_q, blk_d;
    logic [511:0]     out_q, out_d;
    logic             ov_q, ov_d;
    blk_t             in_b, dr_b, inc_b;
    logic [511:0]     sum_flat;
    logic             last;

    function automatic blk_t qr(input blk_t s, input logic [3:0] ia, ib, ic, id);
        word_t a, b, c, d;
        a = s[ia];
        b = s[ib];
        c = s[ic];
        d = s[id];
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        s[ia] = a;
        s[ib] = b;
        s[ic] = c;
        s[id] = d;
        return s;
    endfunction

    function automatic blk_t dround(input blk_t s);
        s = qr(s, 4'd0, 4'd4, 4'd8,  4'd12);
        s = qr(s, 4'd1, 4'd5, 4'd9,  4'd13);
        s = qr(s, 4'd2, 4'd6, 4'd10, 4'd14);
        s = qr(s, 4'd3, 4'd7, 4'd11, 4'd15);
        s = qr(s, 4'd0, 4'd5, 4'd10, 4'd15);
        s = qr(s, 4'd1, 4'd6, 4'd11, 4'd12);
        s = qr(s, 4'd2, 4'd7, 4'd8,  4'd13);
        s = qr(s, 4'd3, 4'd4, 4'd9,  4'd14);
        return s;
    endfunction

    // Element g of a blk_t holds word g; word 0 sits in the top bits of the flat bus.
    for (genvar g = 0; g < 16; g++) begin : g_w
        assign in_b[g]                  = state_in[511-32*g -: 32];
        assign sum_flat[511-32*g -: 32] = dr_b[g] + orig_q[g];
    end

    // Unrolled double rounds applied to the working state this cycle
    always_comb begin
        dr_b = work_q;
        for (int r = 0; r < DR_PER_CYCLE; r++) dr_b = dround(dr_b);
    end

    // Next block's input: block counter bumps with no carry into word 13
    always_comb begin
        inc_b     = orig_q;
        inc_b[12] = orig_q[12] + 32'd1;
    end

    assign last      = (rcnt_q == RW'(N - 1));
    assign in_ready  = (st_q == IDLE);
    assign busy      = (st_q != IDLE);
    assign out_valid = ov_q;
    assign state_out = out_q;

    // Next-state logic for the FSM and all datapath registers
    always_comb begin
        st_d   = st_q;
        work_d = work_q;
        orig_d = orig_q;
        rcnt_d = rcnt_q;
        blk_d  = blk_q;
        out_d  = out_q;
        ov_d   = ov_q;
        case (st_q)
            IDLE: if (in_valid) begin
                st_d   = ROUND;
                orig_d = in_b;
                work_d = in_b;
                rcnt_d = '0;
                blk_d  = (in_nblocks == '0) ? '0 : in_nblocks - 1'b1;
            end
            ROUND: begin
                work_d = dr_b;
                rcnt_d = rcnt_q + 1'b1;
                if (last) begin
                    st_d  = OUT;
                    out_d = sum_flat;
                    ov_d  = 1'b1;
                end
            end
            OUT: if (out_ready) begin
                ov_d = 1'b0;
                if (blk_q == '0) begin
                    st_d = IDLE;
                end else begin
                    st_d   = ROUND;
                    orig_d = inc_b;
                    work_d = inc_b;
                    blk_d  = blk_q - 1'b1;
                    rcnt_d = '0;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // State registers; reset abandons any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            work_q <= '0;
            orig_q <= '0;
            rcnt_q <= '0;
            blk_q  <= '0;
            out_q  <= '0;
            ov_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            work_q <= work_d;
            orig_q <= orig_d;
            rcnt_q <= rcnt_d;
            blk_q  <= blk_d;
            out_q  <= out_d;
            ov_q   <= ov_d;
        end
    end
endmodule

// File: tb/tb_chacha_core_iter.sv
// tb_chacha_core_iter: directed vectors against RFC 8439 values and a software ChaCha model
module tb_chacha_core_iter;
    logic         clk = 1'b0, rst = 1'b1;
    logic [511:0] sin;
    logic [7:0]   nb;
    logic         iv0, iv5, iv2, or0, or5, or2;
    logic         ir0, ir5, ir2, ov0, ov5, ov2, bz0, bz5, bz2;
    logic [511:0] so0, so5, so2;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    chacha_core_iter #(.ROUNDS(20), .DR_PER_CYCLE(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .state_in(sin), .in_nblocks(nb),
        .out_valid(ov0), .out_ready(or0), .state_out(so0), .busy(bz0));
    chacha_core_iter #(.ROUNDS(20), .DR_PER_CYCLE(5), .CNT_W(8)) u5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .state_in(sin), .in_nblocks(nb),
        .out_valid(ov5), .out_ready(or5), .state_out(so5), .busy(bz5));
    chacha_core_iter #(.ROUNDS(20), .DR_PER_CYCLE(2), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .state_in(sin), .in_nblocks(nb),
        .out_valid(ov2), .out_ready(or2), .state_out(so2), .busy(bz2));

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] model(input logic [511:0] s);
        logic [31:0]  x [16];
        logic [31:0]  a, b, c, d;
        logic [511:0] r;
        int           ia, ib, ic, id, j;
        for (int i = 0; i < 16; i++) x[i] = s[511-32*i -: 32];
        for (int rr = 0; rr < 10; rr++) begin
            for (int k = 0; k < 8; k++) begin
                j  = k % 4;
                ia = j;
                ib = (k < 4) ? 4 + j  : 4 + (j + 1) % 4;
                ic = (k < 4) ? 8 + j  : 8 + (j + 2) % 4;
                id = (k < 4) ? 12 + j : 12 + (j + 3) % 4;
                a = x[ia]; b = x[ib]; c = x[ic]; d = x[id];
                a = a + b; d = rl(d ^ a, 16);
                c = c + d; b = rl(b ^ c, 12);
                a = a + b; d = rl(d ^ a, 8);
                c = c + d; b = rl(b ^ c, 7);
                x[ia] = a; x[ib] = b; x[ic] = c; x[id] = d;
            end
        end
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + s[511-32*i -: 32];
        return r;
    endfunction

    function automatic logic [511:0] mk(input logic [31:0] ctr);
        return {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                ctr, 32'h09000000, 32'h4a000000, 32'h00000000};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov0(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ov0 && lat < 64);
    endtask

    typedef struct {
        logic [31:0] ctr;
        logic [7:0]  nb;
        int          nexp;
        bit          kat;
        logic [31:0] w0, w1, w15;
    } vec_t;

    vec_t         vt [5];
    int           lat, l5, l2, cnt;
    logic [511:0] cap;

    initial begin
        vt[0] = '{32'h00000001, 8'd1, 1, 1'b1, 32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2};
        vt[1] = '{32'h00000001, 8'd3, 3, 1'b0, 32'h0, 32'h0, 32'h0};
        vt[2] = '{32'hffffffff, 8'd2, 2, 1'b0, 32'h0, 32'h0, 32'h0};
        vt[3] = '{32'h00000007, 8'd0, 1, 1'b0, 32'h0, 32'h0, 32'h0};
        vt[4] = '{32'h12345678, 8'd2, 2, 1'b0, 32'h0, 32'h0, 32'h0};
        sin = '0; nb = '0;
        iv0 = 0; iv5 = 0; iv2 = 0; or0 = 1; or5 = 1; or2 = 1;
        repeat (3) tick();
        chk("reset in_ready", 512'(ir0), 512'(1));
        chk("reset out_valid", 512'(ov0), 512'(0));
        chk("reset busy", 512'(bz0), 512'(0));
        chk("reset state_out", so0, '0);
        rst = 0;
        tick();

        for (int v = 0; v < 5; v++) begin
            sin = mk(vt[v].ctr); nb = vt[v].nb; iv0 = 1; or0 = 1;
            tick();
            iv0 = 0;
            for (int k = 0; k < vt[v].nexp; k++) begin
                wait_ov0(lat);
                chk($sformatf("v%0d b%0d latency", v, k), 512'(lat), 512'((k == 0) ? 10 : 11));
                chk($sformatf("v%0d b%0d block", v, k), so0, model(mk(vt[v].ctr + k)));
                if (vt[v].kat) begin
                    chk("kat word0", 512'(so0[511 -: 32]), 512'(vt[v].w0));
                    chk("kat word1", 512'(so0[479 -: 32]), 512'(vt[v].w1));
                    chk("kat word15", 512'(so0[31:0]), 512'(vt[v].w15));
                end
            end
            tick();
            chk($sformatf("v%0d done in_ready", v), 512'(ir0), 512'(1));
            chk($sformatf("v%0d done out_valid", v), 512'(ov0), 512'(0));
        end

        sin = mk(32'h1); nb = 8'd1; or5 = 0; or2 = 0; iv5 = 1; iv2 = 1;
        tick();
        iv5 = 0; iv2 = 0; l5 = 0; l2 = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ov5 && l5 == 0) l5 = c;
            if (ov2 && l2 == 0) l2 = c;
        end
        chk("dr5 latency", 512'(l5), 512'(2));
        chk("dr2 latency", 512'(l2), 512'(5));
        chk("dr5 block", so5, model(mk(32'h1)));
        chk("dr2 block", so2, model(mk(32'h1)));
        chk("dr5 word0", 512'(so5[511 -: 32]), 512'(32'he4e7f110));
        or5 = 1; or2 = 1;
        tick();
        chk("dr5 idle", 512'(ir5), 512'(1));
        chk("dr2 idle", 512'(ir2), 512'(1));

        sin = mk(32'h00000042); nb = 8'd1; or0 = 0; iv0 = 1;
        tick();
        iv0 = 0;
        wait_ov0(lat);
        chk("bp latency", 512'(lat), 512'(10));
        cap = so0;
        chk("bp block", cap, model(mk(32'h00000042)));
        sin = mk(32'h99);
        for (int c = 0; c < 7; c++) begin
            iv0 = (c % 2 == 0);
            tick();
            chk("bp state_out stable", so0, cap);
            chk("bp busy", 512'(bz0), 512'(1));
            chk("bp in_ready", 512'(ir0), 512'(0));
            chk("bp out_valid", 512'(ov0), 512'(1));
        end
        iv0 = 0; or0 = 1;
        tick();
        chk("bp release in_ready", 512'(ir0), 512'(1));
        chk("bp release out_valid", 512'(ov0), 512'(0));

        sin = mk(32'h5); nb = 8'd4; or0 = 1; iv0 = 1;
        tick();
        iv0 = 0;
        wait_ov0(lat);
        chk("rst first block", so0, model(mk(32'h5)));
        repeat (3) tick();
        chk("rst pre busy", 512'(bz0), 512'(1));
        rst = 1;
        #1;
        chk("rst async busy", 512'(bz0), 512'(0));
        chk("rst async in_ready", 512'(ir0), 512'(1));
        chk("rst async out_valid", 512'(ov0), 512'(0));
        chk("rst async state_out", so0, '0);
        tick();
        rst = 0;
        tick();
        sin = mk(32'h1); nb = 8'd1; iv0 = 1;
        tick();
        iv0 = 0;
        wait_ov0(lat);
        chk("post rst latency", 512'(lat), 512'(10));
        chk("post rst block", so0, model(mk(32'h1)));
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (ov0) cnt++;
        end
        chk("post rst no leftover", 512'(cnt), 512'(0));
        chk("post rst idle", 512'(bz0), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
